// File: rtl/clock_time_setter_pkg.sv
// ============================================================================
// clock_time_setter_pkg : shared state, field codes and time-limit constants
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_time_setter_pkg;

   typedef enum logic [2:0] {
      RUN      = 3'd0,
      SET_HOUR = 3'd1,
      SET_MIN  = 3'd2,
      SET_SEC  = 3'd3,
      COMMIT   = 3'd4
   } state_t;

   localparam logic [1:0] FIELD_NONE = 2'd0;
   localparam logic [1:0] FIELD_HOUR = 2'd1;
   localparam logic [1:0] FIELD_MIN  = 2'd2;
   localparam logic [1:0] FIELD_SEC  = 2'd3;

   localparam int TIME_W_DEF   = 6;
   localparam int HOUR_MAX_DEF = 23;
   localparam int MIN_MAX_DEF  = 59;

endpackage

`default_nettype wire

// File: rtl/clock_time_setter_key_debounce.sv
// ============================================================================
// key_debounce : 2-flop synchronizer, stable-count debounce, press detect
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic level,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] c_last = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_press;
   logic [CW-1:0] r_cnt;

   // Count consecutive cycles the synchronized key disagrees with the accepted level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_level <= 1'b1;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= key_n;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == c_last) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
            r_press <= ~r_sync2;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign level = r_level;
   assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/clock_time_setter.sv
// ============================================================================
// clock_time_setter : push-button time entry FSM with shadow registers
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_time_setter
   import clock_time_setter_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int          W               = TIME_W_DEF,
   parameter int          HOUR_MAX        = HOUR_MAX_DEF,
   parameter int          MIN_MAX         = MIN_MAX_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tick_1hz,
   input  logic         key_mode_n,
   input  logic         key_inc_n,
   input  logic         key_dec_n,
   input  logic [W-1:0] cur_hour,
   input  logic [W-1:0] cur_min,
   input  logic [W-1:0] cur_sec,
   output logic [W-1:0] set_hour,
   output logic [W-1:0] set_min,
   output logic [W-1:0] set_sec,
   output logic         load,
   output logic         run_en,
   output logic [1:0]   edit_field,
   output logic         blink
);

   localparam logic [W-1:0] c_hour_max = W'(HOUR_MAX);
   localparam logic [W-1:0] c_min_max  = W'(MIN_MAX);

   logic   w_mode_lvl, w_inc_lvl, w_dec_lvl;
   logic   w_mode_prs, w_inc_prs, w_dec_prs;
   logic   w_mode, w_inc, w_dec, w_step, w_in_set;
   state_t r_state, w_next;
   logic [W-1:0] r_hour, r_min, r_sec;
   logic         r_blink;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
      .clk(clk), .rst(rst), .key_n(key_mode_n), .level(w_mode_lvl), .press(w_mode_prs));
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
      .clk(clk), .rst(rst), .key_n(key_inc_n), .level(w_inc_lvl), .press(w_inc_prs));
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_dec (
      .clk(clk), .rst(rst), .key_n(key_dec_n), .level(w_dec_lvl), .press(w_dec_prs));

   assign w_mode   = w_mode_prs & ~w_mode_lvl;
   assign w_inc    = w_inc_prs  & ~w_inc_lvl;
   assign w_dec    = w_dec_prs  & ~w_dec_lvl;
   assign w_step   = (w_inc ^ w_dec) & ~w_mode;
   assign w_in_set = (r_state == SET_HOUR) || (r_state == SET_MIN) || (r_state == SET_SEC);

   function automatic logic [W-1:0] f_step(input logic [W-1:0] v, input logic [W-1:0] max,
                                           input logic up);
      if (up) return (v >= max) ? '0 : v + 1'b1;
      else    return (v == '0) ? max : v - 1'b1;
   endfunction

   function automatic logic [W-1:0] f_clamp(input logic [W-1:0] v, input logic [W-1:0] max);
      return (v > max) ? max : v;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= RUN;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      edit_field = FIELD_NONE;
      case (r_state)
         RUN:      if (w_mode) w_next = SET_HOUR;
         SET_HOUR: begin edit_field = FIELD_HOUR; if (w_mode) w_next = SET_MIN; end
         SET_MIN:  begin edit_field = FIELD_MIN;  if (w_mode) w_next = SET_SEC; end
         SET_SEC:  begin edit_field = FIELD_SEC;  if (w_mode) w_next = COMMIT;  end
         COMMIT:   w_next = RUN;
         default:  w_next = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hour <= '0;
         r_min  <= '0;
         r_sec  <= '0;
      end else if (r_state == RUN && w_mode) begin
         r_hour <= f_clamp(cur_hour, c_hour_max);
         r_min  <= f_clamp(cur_min,  c_min_max);
         r_sec  <= f_clamp(cur_sec,  c_min_max);
      end else if (w_step) begin
         case (r_state)
            SET_HOUR: r_hour <= f_step(r_hour, c_hour_max, w_inc);
            SET_MIN:  r_min  <= f_step(r_min,  c_min_max,  w_inc);
            SET_SEC:  r_sec  <= f_step(r_sec,  c_min_max,  w_inc);
            default:  ;
         endcase
      end
   end

   // Any state change clears blink, so each SET_* field starts visible.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                               r_blink <= 1'b0;
      else if (w_next != r_state || !w_in_set) r_blink <= 1'b0;
      else if (tick_1hz)                      r_blink <= ~r_blink;
   end

   assign set_hour = r_hour;
   assign set_min  = r_min;
   assign set_sec  = r_sec;
   assign load     = (r_state == COMMIT);
   assign run_en   = (r_state == RUN);
   assign blink    = r_blink;

endmodule

`default_nettype wire

// File: tb/tb_clock_time_setter.sv
// ============================================================================
// tb_clock_time_setter : directed self-checking bench for clock_time_setter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_time_setter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick_1hz;
   logic       key_mode_n, key_inc_n, key_dec_n;
   logic [5:0] cur_hour, cur_min, cur_sec;
   logic [5:0] set_hour, set_min, set_sec;
   logic       load, run_en, blink;
   logic [1:0] edit_field;

   int n_checks = 0;
   int n_errors = 0;
   int load_cnt = 0;
   int base;

   always #5 clk = ~clk;

   clock_time_setter #(.DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .rst(rst_n), .tick_1hz(tick_1hz),
      .key_mode_n(key_mode_n), .key_inc_n(key_inc_n), .key_dec_n(key_dec_n),
      .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
      .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
      .load(load), .run_en(run_en), .edit_field(edit_field), .blink(blink));

   always @(negedge clk) if (load === 1'b1) load_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic m, input logic i, input logic d);
      key_mode_n = ~m;
      key_inc_n  = ~i;
      key_dec_n  = ~d;
      cyc(10);
      key_mode_n = 1'b1;
      key_inc_n  = 1'b1;
      key_dec_n  = 1'b1;
      cyc(10);
   endtask

   task automatic tick;
      tick_1hz = 1'b1;
      cyc(1);
      tick_1hz = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; tick_1hz = 1'b0;
      key_mode_n = 1'b1; key_inc_n = 1'b1; key_dec_n = 1'b1;
      cur_hour = 6'd12; cur_min = 6'd34; cur_sec = 6'd56;
      cyc(3);
      check("rst_run_en", run_en, 1);
      check("rst_load", load, 0);
      check("rst_edit", edit_field, 0);
      check("rst_blink", blink, 0);
      check("rst_hour", set_hour, 0);
      check("rst_min", set_min, 0);
      check("rst_sec", set_sec, 0);
      rst_n = 1'b1;
      cyc(2);

      // Enter, capture, increment hour and commit 13:34:56
      press(1, 0, 0);
      check("enter_edit", edit_field, 1);
      check("enter_run_en", run_en, 0);
      check("cap_hour", set_hour, 12);
      check("cap_min", set_min, 34);
      check("cap_sec", set_sec, 56);
      press(0, 1, 0);
      check("inc_hour", set_hour, 13);
      press(1, 0, 0);
      check("edit_min", edit_field, 2);
      press(1, 0, 0);
      check("edit_sec", edit_field, 3);
      base = load_cnt;
      key_mode_n = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (load === 1'b1) break;
         @(negedge clk);
      end
      check("commit_load", load, 1);
      check("commit_hour", set_hour, 13);
      check("commit_min", set_min, 34);
      check("commit_sec", set_sec, 56);
      check("commit_edit", edit_field, 0);
      check("commit_run_en_low", run_en, 0);
      cyc(1);
      check("post_load", load, 0);
      check("post_run_en", run_en, 1);
      check("post_edit", edit_field, 0);
      key_mode_n = 1'b1;
      cyc(10);
      check("load_pulses", load_cnt - base, 1);
      check("hold_hour", set_hour, 13);

      // Wrap cases and clamp on capture
      cur_hour = 6'd23; cur_min = 6'd62; cur_sec = 6'd7;
      press(1, 0, 0);
      check("cap23_hour", set_hour, 23);
      check("clamp_min", set_min, 59);
      check("cap_sec7", set_sec, 7);
      press(0, 1, 0);
      check("hour_wrap_up", set_hour, 0);
      press(0, 0, 1);
      check("hour_wrap_dn", set_hour, 23);
      press(1, 0, 0);
      press(0, 1, 0);
      check("min_wrap_up", set_min, 0);
      press(0, 0, 1);
      check("min_wrap_dn", set_min, 59);

      // Bounce: only the final stable low stretch yields one event
      key_inc_n = 1'b0; cyc(3);
      key_inc_n = 1'b1; cyc(1);
      key_inc_n = 1'b0; cyc(10);
      key_inc_n = 1'b1; cyc(12);
      check("bounce_min", set_min, 0);

      // Inc and dec together are ignored
      press(0, 1, 1);
      check("incdec_min", set_min, 0);
      check("incdec_edit", edit_field, 2);

      // Mode wins over inc in the same cycle
      press(1, 0, 0);
      press(1, 0, 0);
      cyc(2);
      check("back_run", run_en, 1);
      press(1, 0, 0);
      check("recap_hour", set_hour, 23);
      press(1, 1, 0);
      check("modeinc_edit", edit_field, 2);
      check("modeinc_hour", set_hour, 23);

      // Blink toggles on each tick while editing
      check("blink_entry", blink, 0);
      tick; check("blink_1", blink, 1);
      cyc(2);
      tick; check("blink_2", blink, 0);
      cyc(2);
      tick; check("blink_3", blink, 1);

      // Reset during SET_SEC discards the edit without a load
      press(1, 0, 0);
      check("pre_rst_edit", edit_field, 3);
      check("blink_reentry", blink, 0);
      base = load_cnt;
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_edit", edit_field, 0);
      check("mid_rst_run_en", run_en, 1);
      check("mid_rst_load", load, 0);
      check("mid_rst_hour", set_hour, 0);
      check("mid_rst_min", set_min, 0);
      check("mid_rst_sec", set_sec, 0);
      cyc(3);
      rst_n = 1'b1;
      cyc(10);
      check("mid_rst_no_load", load_cnt - base, 0);
      check("after_rst_run_en", run_en, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
